spi_ext_slave: RTL and testbench
================================

# spi_ext_slave

SPI mode-0 slave (responder) for the external expansion SPI bus: the board-side end of one `ext_cs` line driven by the ZX-UNO core's SPI master. It oversamples `ext_clk`, `ext_di` and one `ext_cs` line on the system clock and presents received bytes on a parallel strobe interface. It shifts out bytes from a one-deep transmit holding register, so peripheral logic in the expansion FPGA or CPLD can exchange full-duplex byte streams with the core.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on spi_clk/spi_mosi/spi_cs_n (2 or 3).
- `TX_IDLE`, 8'hFF: byte shifted out when holding register is empty.
- `clk` in 1: system clock, all logic on rising edge; must be at least 8x spi_clk frequency.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_cs_n` in 1: chip select from master, active low (asynchronous pin).
- `spi_clk` in 1: SPI clock, idle low (asynchronous pin).
- `spi_mosi` in 1: master-to-slave data (the master's `ext_di`).
- `spi_miso` out 1: slave-to-master data (the master's `ext_do`).
- `spi_miso_oe` out 1: MISO tristate enable, high while selected.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: one-cycle strobe, rx_data updated.
- `rx_first` out 1: qualifies rx_valid, byte is first of the frame.
- `tx_data` in 8: byte to transmit.
- `tx_wr` in 1: one-cycle write strobe for tx_data.
- `tx_ready` out 1: holding register empty.
- `frame_start` out 1: one-cycle pulse on detected CS assertion.
- `frame_end` out 1: one-cycle pulse on detected CS deassertion.
- `abort` out 1: one-cycle pulse, CS deasserted with partial byte (1–7 bits).
- `tx_underrun` out 1: one-cycle pulse, TX_IDLE substituted.
- `tx_overflow` out 1: one-cycle pulse, tx_wr ignored because holding register full.

## Operation
- Inputs pass through SYNC_STAGES flops plus one edge-detect flop. Edges are detected from the last two stages. MOSI is taken from the same stage as SCLK, so relative timing is preserved.
- FSM states:
  - **IDLE**: synchronised CS high; spi_miso_oe=0; bit counter held at 0.
  - **LOAD**: one cycle after the CS falling edge is detected. Shift register loads from the holding register, or TX_IDLE if empty. spi_miso takes bit 7. frame_start pulses. Next state is SHIFT.
  - **SHIFT**:
    - Rising SCLK: MOSI is shifted into rx shift register LSB, MSB first, and the counter increments mod 8.
    - On the 8th rising edge: rx_data is loaded, rx_valid pulses, rx_first=1 only for the frame's first byte, and the next tx byte is loaded into the shift register (holding or TX_IDLE).
    - Falling SCLK: spi_miso presents the next bit. After byte completion it presents bit 7 of the newly loaded byte.
  - **CS rising edge from SHIFT**: frame_end pulses; abort also pulses if counter≠0; partial rx bits are discarded; return to IDLE.
- Holding register:
  - tx_wr while tx_ready=1: store the byte, tx_ready←0.
  - tx_wr while tx_ready=0: ignore, tx_overflow pulses.
  - Consumption (LOAD or byte completion) sets tx_ready←1, except when tx_wr arrives in the same cycle: the old byte is consumed, the new byte is stored, and tx_ready stays 0 with no overflow.
  - Consumption with the register empty sends TX_IDLE and tx_underrun pulses.
  - An unconsumed byte survives frame end and abort, and is sent first in the next frame.
- SCLK edges seen while in IDLE or LOAD are ignored.
- CS falling and rising edges detected in consecutive cycles (glitch): LOAD completes, then frame_end; no byte is produced.
- Reset (any time, including mid-frame): FSM IDLE, counter 0, shift registers 0, synchronisers to idle values (cs_n=1, clk=0), holding empty.

## Timing
- Reset values: spi_miso=1, spi_miso_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_ready=1, and all pulse outputs 0.
- Edge detected SYNC_STAGES to SYNC_STAGES+1 clk after the pin edge; registered outputs change one clk after detection.
- rx_valid is high exactly one clk per complete byte, rx_data is stable until the next rx_valid, and both occur before the next falling SCLK is detected.
- spi_miso changes only in LOAD and on detected falling SCLK. A master must allow at least SYNC_STAGES+3 clk between CS low and the first SCLK rise, and half-period ≥ 4 clk.
- spi_miso_oe rises in LOAD and falls in the cycle frame_end pulses.

## Test plan
- **Single byte**: tx_wr 8'hA5, then CS low, master sends 8'h3C at clk/8 → MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with rx_valid and rx_first for 1 clk; tx_ready rises in LOAD; frame_start/frame_end each pulse once.
- **Three-byte burst with refill**: tx 8'h01, then 8'h02 written after the first tx_ready; master sends 8'h10, 8'h20, 8'h30 → MISO 01,02,FF; tx_underrun on byte 3; rx_first only with 8'h10.
- **Abort**: CS high after 5 bits → no rx_valid; abort and frame_end pulse; next frame's first byte has rx_first=1 and correct data.
- **Overflow / simultaneous**: tx_wr 8'h11 then 8'h22 while full → tx_overflow, 8'h11 sent. Then tx_wr 8'h33 coinciding with the consume cycle → no overflow, tx_ready=0, 8'h33 sent next byte.
- **Reset mid-frame**: assert rst_n low after 12 bits → outputs at reset values immediately. Release, then a fresh frame returns a correct byte with rx_first=1.
- **Timing limits**: SYNC_STAGES=3, SCLK half-period exactly 4 clk, random data over 256 bytes → zero mismatches against the reference model.

Source files
------------

// File: rtl/spi_ext_slave.sv
// SPI mode-0 responder for the expansion bus: oversamples the SPI pins on clk,
// presents received bytes on a strobe interface and shifts out a one-deep TX holding register.
module spi_ext_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  TX_IDLE     = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_ready,
  output logic       frame_start,
  output logic       frame_end,
  output logic       abort,
  output logic       tx_underrun,
  output logic       tx_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES:0]   cs_sync_q, sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  logic       cs_cur, cs_fall, sclk_rise, sclk_fall, mosi_cur;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [7:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic       tx_ready_q, tx_ready_d, first_q, first_d;
  logic       miso_q, miso_d, oe_q, oe_d;
  logic       rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
  logic       fstart_q, fstart_d, fend_q, fend_d, abort_q, abort_d;
  logic       under_q, under_d, over_q, over_d;
  logic       consume;
  logic [7:0] next_byte;

  // Last stage of each chain is the edge-detect flop; MOSI shares SCLK's sampling stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign cs_cur    = cs_sync_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_cur & cs_sync_q[SYNC_STAGES];
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
  assign mosi_cur  = mosi_sync_q[SYNC_STAGES-1];
  assign next_byte = tx_ready_q ? TX_IDLE : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // CS is tested as a level in SHIFT so a rise seen during LOAD still ends the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cs_fall) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (cs_cur) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    rx_data_d  = rx_data_q;
    first_d    = first_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    fstart_d   = 1'b0;
    fend_d     = 1'b0;
    abort_d    = 1'b0;
    consume    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) begin
          consume  = 1'b1;
          tx_sr_d  = {next_byte[6:0], 1'b0};
          miso_d   = next_byte[7];
          oe_d     = 1'b1;
          fstart_d = 1'b1;
          first_d  = 1'b1;
          rx_sr_d  = '0;
        end
      end
      S_SHIFT: begin
        if (cs_cur) begin
          fend_d    = 1'b1;
          abort_d   = (bit_cnt_q != 3'd0);
          oe_d      = 1'b0;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
        end else if (sclk_rise) begin
          bit_cnt_d = 3'(bit_cnt_q + 3'd1);
          rx_sr_d   = {rx_sr_q[6:0], mosi_cur};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_sr_q[6:0], mosi_cur};
            rx_valid_d = 1'b1;
            rx_first_d = first_q;
            first_d    = 1'b0;
            consume    = 1'b1;
            tx_sr_d    = next_byte;
          end
        end else if (sclk_fall) begin
          // tx_sr_q[7] is always the next bit owed to the master, including a freshly loaded byte.
          miso_d  = tx_sr_q[7];
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // A write landing on a consume cycle refills the register instead of overflowing.
  always_comb begin
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    under_d    = 1'b0;
    over_d     = 1'b0;
    if (consume) begin
      under_d    = tx_ready_q;
      tx_ready_d = 1'b1;
    end
    if (tx_wr) begin
      if (tx_ready_q || consume) begin
        hold_d     = tx_data;
        tx_ready_d = 1'b0;
      end else begin
        over_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b1;
      first_q    <= 1'b0;
      miso_q     <= 1'b1;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      fstart_q   <= 1'b0;
      fend_q     <= 1'b0;
      abort_q    <= 1'b0;
      under_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      first_q    <= first_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      fstart_q   <= fstart_d;
      fend_q     <= fend_d;
      abort_q    <= abort_d;
      under_q    <= under_d;
      over_q     <= over_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_first    = rx_first_q;
  assign tx_ready    = tx_ready_q;
  assign frame_start = fstart_q;
  assign frame_end   = fend_q;
  assign abort       = abort_q;
  assign tx_underrun = under_q;
  assign tx_overflow = over_q;

endmodule

// File: tb/tb_spi_ext_slave.sv
// Bench for spi_ext_slave: an SPI master model plus a frame/byte-level reference of the
// holding register, checked by a per-cycle monitor and per-byte MISO comparisons.
module tb_spi_ext_slave;
  localparam int unsigned SYNC = 3;
  localparam int unsigned H    = 4;
  localparam logic [7:0]  IDLE_B = 8'hFF;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       spi_cs_n = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0, tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       spi_miso, spi_miso_oe, rx_valid, rx_first, tx_ready;
  logic       frame_start, frame_end, abort, tx_underrun, tx_overflow;
  logic [7:0] rx_data;

  int errors = 0, checks = 0;
  int exp_start = 0, exp_end = 0, exp_abort = 0, exp_under = 0, exp_over = 0;
  int n_start = 0, n_end = 0, n_abort = 0, n_under = 0, n_over = 0;

  logic [7:0] m_hold = 8'h00, m_cur = 8'h00;
  bit         m_full = 1'b0, m_first = 1'b0;
  logic [7:0] rxq_data[$];
  bit         rxq_first[$];

  always #5 clk = ~clk;

  spi_ext_slave #(.SYNC_STAGES(SYNC), .TX_IDLE(IDLE_B)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_first(rx_first), .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
    .frame_start(frame_start), .frame_end(frame_end), .abort(abort),
    .tx_underrun(tx_underrun), .tx_overflow(tx_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference holding register: one slot, consumed at frame start and after every whole byte.
  task automatic m_consume(output logic [7:0] b);
    if (m_full) begin b = m_hold; m_full = 1'b0; end
    else begin b = IDLE_B; exp_under++; end
  endtask

  task automatic m_write(input logic [7:0] d);
    if (!m_full) begin m_hold = d; m_full = 1'b1; end
    else exp_over++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (rxq_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected: got rx_valid with %0h expected no byte", rx_data);
        end else begin
          chk("rx_data", rx_data, rxq_data.pop_front());
          chk("rx_first", rx_first, rxq_first.pop_front());
        end
      end
      if (frame_start) n_start++;
      if (frame_end)   n_end++;
      if (abort)       n_abort++;
      if (tx_underrun) n_under++;
      if (tx_overflow) n_over++;
    end
  end

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk); tx_data = d; tx_wr = 1'b1; m_write(d);
    @(negedge clk); tx_wr = 1'b0;
    @(negedge clk); chk("tx_ready_wr", tx_ready, !m_full);
  endtask

  task automatic cs_assert(input bit do_wr, input logic [7:0] wd);
    @(negedge clk); spi_cs_n = 1'b0;
    exp_start++; m_consume(m_cur); m_first = 1'b1;
    repeat (SYNC) @(negedge clk);
    if (do_wr) begin tx_data = wd; tx_wr = 1'b1; m_write(wd); end
    @(negedge clk); tx_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("miso_oe_sel", spi_miso_oe, 1'b1);
    chk("tx_ready_load", tx_ready, !m_full);
  endtask

  task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi,
                           input bit wr_mid, input logic [7:0] wd);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      repeat (H) @(negedge clk);
      mi = {mi[6:0], spi_miso};
      spi_clk = 1'b1;
      if (wr_mid && i == 3) begin
        tx_data = wd; tx_wr = 1'b1; m_write(wd);
        @(negedge clk); tx_wr = 1'b0;
        repeat (H-1) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic xfer_byte(input logic [7:0] mo, input bit wr_mid, input logic [7:0] wd,
                           output logic [7:0] mi);
    logic [7:0] expb;
    expb = m_cur;
    rxq_data.push_back(mo); rxq_first.push_back(m_first); m_first = 1'b0;
    xfer_bits(mo, 8, mi, wr_mid, wd);
    chk("miso_byte", mi, expb);
    m_consume(m_cur);
  endtask

  task automatic cs_deassert(input bit partial);
    repeat (H) @(negedge clk);
    spi_cs_n = 1'b1; exp_end++;
    if (partial) exp_abort++;
    repeat (SYNC + 3) @(negedge clk);
    chk("miso_oe_desel", spi_miso_oe, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_start"}, n_start, exp_start);
    chk({tag, "_frame_end"}, n_end, exp_end);
    chk({tag, "_abort"}, n_abort, exp_abort);
    chk({tag, "_underrun"}, n_under, exp_under);
    chk({tag, "_overflow"}, n_over, exp_over);
    chk({tag, "_rx_missing"}, rxq_data.size(), 0);
  endtask

  initial begin
    logic [7:0] mi;
    int nbytes, nb;
    repeat (3) @(negedge clk);
    chk("rst_miso", spi_miso, 1'b1);
    chk("rst_oe", spi_miso_oe, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_pulses", {frame_start, frame_end, abort, tx_underrun, tx_overflow, rx_first}, 6'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte
    tx_write(8'hA5);
    chk("t1_tx_ready_full", tx_ready, 1'b0);
    cs_assert(1'b0, 8'h00);
    chk("t1_tx_ready_load", tx_ready, 1'b1);
    xfer_byte(8'h3C, 1'b0, 8'h00, mi);
    chk("t1_miso", mi, 8'hA5);
    cs_deassert(1'b0);
    chk("t1_rx_data_hold", rx_data, 8'h3C);
    check_counts("t1");

    // Three-byte burst with refill
    tx_write(8'h01);
    cs_assert(1'b0, 8'h00);
    xfer_byte(8'h10, 1'b1, 8'h02, mi); chk("t2_miso0", mi, 8'h01);
    xfer_byte(8'h20, 1'b0, 8'h00, mi); chk("t2_miso1", mi, 8'h02);
    xfer_byte(8'h30, 1'b0, 8'h00, mi); chk("t2_miso2", mi, 8'hFF);
    cs_deassert(1'b0);
    check_counts("t2");

    // Abort after 5 bits, then a clean frame
    cs_assert(1'b0, 8'h00);
    xfer_bits(8'hB7, 5, mi, 1'b0, 8'h00);
    cs_deassert(1'b1);
    cs_assert(1'b0, 8'h00);
    xfer_byte(8'h6E, 1'b0, 8'h00, mi);
    cs_deassert(1'b0);
    check_counts("t3");

    // Overflow, then write coinciding with the LOAD consume
    tx_write(8'h11);
    tx_write(8'h22);
    cs_assert(1'b1, 8'h33);
    chk("t4_tx_ready", tx_ready, 1'b0);
    xfer_byte(8'h44, 1'b0, 8'h00, mi); chk("t4_miso0", mi, 8'h11);
    xfer_byte(8'h55, 1'b0, 8'h00, mi); chk("t4_miso1", mi, 8'h33);
    cs_deassert(1'b0);
    chk("t4_overflow_cnt", n_over, 1);
    check_counts("t4");

    // CS glitch: one-clk low pulse
    @(negedge clk); spi_cs_n = 1'b0; exp_start++; m_consume(m_cur);
    @(negedge clk); spi_cs_n = 1'b1; exp_end++;
    repeat (SYNC + 6) @(negedge clk);
    chk("t5_oe", spi_miso_oe, 1'b0);
    check_counts("t5");

    // Reset mid-frame after 12 bits
    tx_write(8'h5A);
    cs_assert(1'b0, 8'h00);
    xfer_byte(8'hC3, 1'b0, 8'h00, mi); chk("t6_miso0", mi, 8'h5A);
    xfer_bits(8'hF0, 4, mi, 1'b0, 8'h00);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t6_rst_miso", spi_miso, 1'b1);
    chk("t6_rst_oe", spi_miso_oe, 1'b0);
    chk("t6_rst_rx_data", rx_data, 8'h00);
    chk("t6_rst_tx_ready", tx_ready, 1'b1);
    chk("t6_rst_pulses", {frame_start, frame_end, abort, tx_underrun, tx_overflow, rx_valid}, 6'b0);
    spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    m_full = 1'b0; rxq_data.delete(); rxq_first.delete();
    exp_start = 0; exp_end = 0; exp_abort = 0; exp_under = 0; exp_over = 0;
    n_start = 0; n_end = 0; n_abort = 0; n_under = 0; n_over = 0;
    repeat (4) @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_assert(1'b0, 8'h00);
    xfer_byte(8'h96, 1'b0, 8'h00, mi); chk("t6_miso_after", mi, 8'hFF);
    cs_deassert(1'b0);
    check_counts("t6");

    // Random traffic at the minimum half-period
    nbytes = 0;
    while (nbytes < 256) begin
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      nb = $urandom_range(1, 6);
      cs_assert(1'b0, 8'h00);
      for (int k = 0; k < nb; k++) begin
        xfer_byte(8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom), mi);
        nbytes++;
      end
      if ($urandom_range(0, 7) == 0) begin
        xfer_bits(8'($urandom), $urandom_range(1, 7), mi, 1'b0, 8'h00);
        cs_deassert(1'b1);
      end else begin
        cs_deassert(1'b0);
      end
    end
    check_counts("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no completion expected finish within 5ms");
    $fatal(1, "timeout");
  end

endmodule
